// File: rtl/bbm_pkg.sv
// Shared types and defaults for the break-before-make sequencer.
package bbm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DT_H = 3'd1,
        HS   = 3'd2,
        DT_L = 3'd3,
        LS   = 3'd4,
        FLT  = 3'd5
    } bbm_state_t;

    localparam int DTW_DEF   = 6;
    localparam int MINON_DEF = 4;

endpackage

// File: rtl/bbm_dtcnt.sv
// Loadable down-counter; done marks the last counted cycle (count==1).
// It saturates at zero, so a stray decrement can never wrap into a long interval.
module bbm_dtcnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    input  logic         dec_i,
    output logic         done_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == W'(1));
    assign zero_o = (count_q == '0);

endmodule

// File: rtl/bbm_seq_ctrl.sv
// Break-before-make sequencer: one PWM request -> non-overlapping HS/LS enables with dead time.
// Optional min-on hold for HS/LS is enabled with the BBM_MINON_EN macro.
module bbm_seq_ctrl
    import bbm_pkg::*;
#(
    parameter int DTW   = DTW_DEF,
    parameter int MINON = MINON_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           SUB,
    input  logic           i,
    input  logic           en,
    input  logic [DTW-1:0] dt_cfg,
    input  logic           flt,
    output logic           hs_o,
    output logic           ls_o,
    output logic           busy,
    output logic           flt_o
);

    bbm_state_t state_q;
    bbm_state_t state_d;

    logic           dtLoad;
    logic           dtDec;
    logic           dtDone;
    logic [DTW-1:0] dtLoadVal;
    logic           toggleOk;

    logic hs_q;
    logic ls_q;
    logic busy_q;
    logic flt_q;

    // Supply pins exist only for the symbol/netlist generator.
    logic unusedSupply;
    assign unusedSupply = ^{CELV, CELG, SUB};

    assign dtLoadVal = (dt_cfg == '0) ? DTW'(1) : dt_cfg;

    logic unusedDtZero;

    bbm_dtcnt #(.W(DTW)) dtCnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (dtLoad),
        .loadVal_i (dtLoadVal),
        .dec_i     (dtDec),
        .done_o    (dtDone),
        .zero_o    (unusedDtZero)
    );

`ifdef BBM_MINON_EN
    logic mnLoad;
    logic mnDec;
    logic mnDone;
    logic mnZero;

    // Toggle is honoured on the edge where the hold expires, so HS/LS last at least MINON cycles.
    assign mnLoad   = ((state_d == HS) || (state_d == LS)) && (state_d != state_q);
    assign mnDec    = (state_q == HS) || (state_q == LS);
    assign toggleOk = mnDone || mnZero;

    bbm_dtcnt #(.W(DTW)) minOnCnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (mnLoad),
        .loadVal_i (DTW'(MINON)),
        .dec_i     (mnDec),
        .done_o    (mnDone),
        .zero_o    (mnZero)
    );
`else
    logic [DTW-1:0] unusedMinon;
    assign unusedMinon = DTW'(MINON);
    assign toggleOk    = 1'b1;
`endif

    // Next state: fault beats disable beats normal sequencing. During dead time the
    // counter keeps running across a reversal since both switches are already off.
    always_comb begin
        state_d = state_q;
        dtLoad  = 1'b0;
        dtDec   = 1'b0;
        if (flt) begin
            state_d = FLT;
        end else if (state_q == FLT) begin
            if (!en) begin
                state_d = IDLE;
            end
        end else if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = i ? DT_H : DT_L;
                    dtLoad  = 1'b1;
                end
                DT_H, DT_L: begin
                    dtDec = 1'b1;
                    if (dtDone) begin
                        state_d = i ? HS : LS;
                    end else begin
                        state_d = i ? DT_H : DT_L;
                    end
                end
                HS: begin
                    if (!i && toggleOk) begin
                        state_d = DT_L;
                        dtLoad  = 1'b1;
                    end
                end
                LS: begin
                    if (i && toggleOk) begin
                        state_d = DT_H;
                        dtLoad  = 1'b1;
                    end
                end
                default: state_d = FLT;
            endcase
        end
    end

    // Outputs are registered from the next state so they always match state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
            busy_q  <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= (state_d == HS);
            ls_q    <= (state_d == LS);
            busy_q  <= (state_d == DT_H) || (state_d == DT_L);
            flt_q   <= (state_d == FLT);
        end
    end

    assign hs_o  = hs_q;
    assign ls_o  = ls_q;
    assign busy  = busy_q;
    assign flt_o = flt_q;

endmodule
